exec_cluster: RTL and testbench

Parametrised execute cluster for the superscalar core: `NUM_LANES` independent integer lanes, each with a registered result stage, an iterative multi-cycle multiply, and a valid/ready issue handshake. Completed results are broadcast on a per-lane result bus. The same results are matched against `NUM_SNOOP` reservation-station tag ports so waiting operands can capture forwarded data. It replaces the fixed two-ALU combinational execute stage with a pipelined, width- and lane-configurable block.

---
 rtl/exec_cluster_if.sv | 40 ++++
 rtl/exec_cluster.sv | 198 +++++++++++++++++++
 tb/tb_exec_cluster.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_cluster_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_cluster_if
// Brief    : Issue, result-broadcast and reservation-station snoop bundle
//            for the exec_cluster execute block.
// Revision : 1.0
// ============================================================================
interface exec_cluster_if #(
    parameter int NUM_LANES = 2,
    parameter int NUM_SNOOP = 8,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 32
);
    logic                           Flush;
    logic [NUM_LANES-1:0]           InValid;
    logic [NUM_LANES-1:0]           InReady;
    logic [4*NUM_LANES-1:0]         ALUControl;
    logic [DATA_W*NUM_LANES-1:0]    SrcA;
    logic [DATA_W*NUM_LANES-1:0]    SrcB;
    logic [TAG_W*NUM_LANES-1:0]     Dest;
    logic [NUM_LANES-1:0]           RegWrite;
    logic [NUM_LANES-1:0]           ResValid;
    logic [DATA_W*NUM_LANES-1:0]    ResData;
    logic [TAG_W*NUM_LANES-1:0]     ResDest;
    logic [NUM_LANES-1:0]           ResRegWrite;
    logic [TAG_W*NUM_SNOOP-1:0]     SnoopTag;
    logic [NUM_SNOOP-1:0]           SnoopHit;
    logic [DATA_W*NUM_SNOOP-1:0]    SnoopData;

    modport master (
        output Flush, InValid, ALUControl, SrcA, SrcB, Dest, RegWrite, SnoopTag,
        input  InReady, ResValid, ResData, ResDest, ResRegWrite, SnoopHit, SnoopData
    );

    modport slave (
        input  Flush, InValid, ALUControl, SrcA, SrcB, Dest, RegWrite, SnoopTag,
        output InReady, ResValid, ResData, ResDest, ResRegWrite, SnoopHit, SnoopData
    );
endinterface
`default_nettype wire

// File: rtl/exec_cluster.sv
`default_nettype none
// ============================================================================
// Module   : exec_cluster
// Brief    : NUM_LANES independent integer lanes with registered results,
//            multi-cycle multiply and reservation-station tag snooping.
// Revision : 1.0
// ============================================================================
module exec_cluster #(
    parameter int NUM_LANES  = 2,
    parameter int NUM_SNOOP  = 8,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 32,
    parameter int MUL_CYCLES = 4
) (
    input  wire logic     CLK,
    input  wire logic     Reset,
    exec_cluster_if.slave bus
);
    localparam int c_CNT_W = $clog2(MUL_CYCLES) + 1;

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_SLL = 4'b1000;
    localparam logic [3:0] c_OP_SRL = 4'b1001;
    localparam logic [3:0] c_OP_MUL = 4'b1010;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic [NUM_LANES*DATA_W-1:0] w_res_data;
    logic [NUM_LANES*TAG_W-1:0]  w_res_dest;
    logic [NUM_LANES-1:0]        w_res_valid;
    logic [NUM_LANES-1:0]        w_res_rw;
    logic [NUM_LANES-1:0]        w_in_ready;
    logic [NUM_SNOOP-1:0]        w_snoop_hit;
    logic [NUM_SNOOP*DATA_W-1:0] w_snoop_data;

    function automatic logic [DATA_W-1:0] f_alu(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            c_OP_AND: r = a & b;
            c_OP_OR:  r = a | b;
            c_OP_ADD: r = a + b;
            c_OP_XOR: r = a ^ b;
            c_OP_SUB: r = a - b;
            c_OP_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLL: r = a << b[4:0];
            c_OP_SRL: r = a >> b[4:0];
            c_OP_NOR: r = ~(a | b);
            default:  r = '0;
        endcase
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            state_t              r_state;
            state_t              w_state_nx;
            logic [c_CNT_W-1:0]  r_count;
            logic [c_CNT_W-1:0]  w_count_nx;
            logic [DATA_W-1:0]   r_mul_a;
            logic [DATA_W-1:0]   r_mul_b;
            logic [TAG_W-1:0]    r_mul_dest;
            logic                r_mul_rw;
            logic                r_res_valid;
            logic [DATA_W-1:0]   r_res_data;
            logic [TAG_W-1:0]    r_res_dest;
            logic                r_res_rw;
            logic [3:0]          w_op;
            logic [DATA_W-1:0]   w_a;
            logic [DATA_W-1:0]   w_b;
            logic [TAG_W-1:0]    w_dest;
            logic [DATA_W-1:0]   w_alu;
            logic [DATA_W-1:0]   w_prod;
            logic                w_accept;
            logic                w_mul_start;
            logic                w_res_load;
            logic                w_res_from_mul;

            assign w_op   = bus.ALUControl[gi*4 +: 4];
            assign w_a    = bus.SrcA[gi*DATA_W +: DATA_W];
            assign w_b    = bus.SrcB[gi*DATA_W +: DATA_W];
            assign w_dest = bus.Dest[gi*TAG_W +: TAG_W];
            assign w_alu  = f_alu(w_op, w_a, w_b);
            assign w_prod = r_mul_a * r_mul_b;

            assign w_in_ready[gi] = !Reset && (r_state == ST_IDLE);
            assign w_accept       = bus.InValid[gi] && w_in_ready[gi] && !bus.Flush;

            always_comb begin
                w_state_nx     = r_state;
                w_count_nx     = r_count;
                w_mul_start    = 1'b0;
                w_res_load     = 1'b0;
                w_res_from_mul = 1'b0;
                if (bus.Flush) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_accept) begin
                                if (w_op == c_OP_MUL) begin
                                    w_state_nx  = ST_BUSY;
                                    w_count_nx  = c_CNT_W'(MUL_CYCLES - 1);
                                    w_mul_start = 1'b1;
                                end else begin
                                    w_res_load = 1'b1;
                                end
                            end
                        end
                        ST_BUSY: begin
                            w_count_nx = r_count - 1'b1;
                            if (r_count == c_CNT_W'(1)) begin
                                w_state_nx     = ST_IDLE;
                                w_res_load     = 1'b1;
                                w_res_from_mul = 1'b1;
                            end
                        end
                        default: w_state_nx = ST_IDLE;
                    endcase
                end
            end

            // Result data/tag hold on flush; only the valid pulse is cleared.
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    r_state     <= ST_IDLE;
                    r_count     <= '0;
                    r_mul_a     <= '0;
                    r_mul_b     <= '0;
                    r_mul_dest  <= '0;
                    r_mul_rw    <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_res_data  <= '0;
                    r_res_dest  <= '0;
                    r_res_rw    <= 1'b0;
                end else begin
                    r_state     <= w_state_nx;
                    r_count     <= w_count_nx;
                    r_res_valid <= w_res_load;
                    if (w_mul_start) begin
                        r_mul_a    <= w_a;
                        r_mul_b    <= w_b;
                        r_mul_dest <= w_dest;
                        r_mul_rw   <= bus.RegWrite[gi];
                    end
                    if (w_res_load) begin
                        r_res_data <= w_res_from_mul ? w_prod     : w_alu;
                        r_res_dest <= w_res_from_mul ? r_mul_dest : w_dest;
                        r_res_rw   <= w_res_from_mul ? r_mul_rw   : bus.RegWrite[gi];
                    end
                end
            end

            assign w_res_valid[gi]                 = r_res_valid;
            assign w_res_rw[gi]                    = r_res_rw;
            assign w_res_data[gi*DATA_W +: DATA_W] = r_res_data;
            assign w_res_dest[gi*TAG_W +: TAG_W]   = r_res_dest;
        end
    endgenerate

    // Lanes scanned high to low so the lowest-index match is written last.
    always_comb begin
        w_snoop_hit  = '0;
        w_snoop_data = '0;
        for (int j = 0; j < NUM_SNOOP; j++) begin
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                if (w_res_valid[i] && w_res_rw[i] &&
                    (w_res_dest[i*TAG_W +: TAG_W] == bus.SnoopTag[j*TAG_W +: TAG_W])) begin
                    w_snoop_hit[j]                   = 1'b1;
                    w_snoop_data[j*DATA_W +: DATA_W] = w_res_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.InReady     = w_in_ready;
    assign bus.ResValid    = w_res_valid;
    assign bus.ResData     = w_res_data;
    assign bus.ResDest     = w_res_dest;
    assign bus.ResRegWrite = w_res_rw;
    assign bus.SnoopHit    = w_snoop_hit;
    assign bus.SnoopData   = w_snoop_data;
endmodule
`default_nettype wire

// File: tb/tb_exec_cluster.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_cluster
// Brief    : Directed and randomized checks of exec_cluster against a
//            cycle-indexed behavioural model.
// Revision : 1.0
// ============================================================================
module tb_exec_cluster;
    localparam int NL = 2;
    localparam int NS = 8;
    localparam int DW = 32;
    localparam int TW = 32;
    localparam int MC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_cluster_if #(.NUM_LANES(NL), .NUM_SNOOP(NS), .DATA_W(DW), .TAG_W(TW)) bus_if ();

    exec_cluster #(
        .NUM_LANES (NL),
        .NUM_SNOOP (NS),
        .DATA_W    (DW),
        .TAG_W     (TW),
        .MUL_CYCLES(MC)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    // Model: visible result stage plus one pending multiply per lane with its due cycle.
    logic          m_valid [NL];
    logic [DW-1:0] m_data  [NL];
    logic [TW-1:0] m_dest  [NL];
    logic          m_rw    [NL];
    bit            m_pend  [NL];
    int            m_due   [NL];
    logic [DW-1:0] m_pdata [NL];
    logic [TW-1:0] m_pdest [NL];
    logic          m_prw   [NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b0111: return DW'(($signed(a) < $signed(b)) ? 1 : 0);
            4'b1000: return a << b[4:0];
            4'b1001: return a >> b[4:0];
            4'b1100: return ~(a | b);
            4'b1010: return a * b;
            default: return '0;
        endcase
    endfunction

    function automatic bit exp_ready(input int l);
        return !rst && !(m_pend[l] && cyc < m_due[l]);
    endfunction

    task automatic model_edge();
        for (int l = 0; l < NL; l++) begin
            logic [3:0]    op;
            logic [DW-1:0] a, b;
            bit            rdy;
            op  = bus_if.ALUControl[l*4 +: 4];
            a   = bus_if.SrcA[l*DW +: DW];
            b   = bus_if.SrcB[l*DW +: DW];
            rdy = exp_ready(l);
            if (rst) begin
                m_valid[l] = 0; m_data[l] = '0; m_dest[l] = '0; m_rw[l] = 0; m_pend[l] = 0;
            end else if (bus_if.Flush) begin
                m_valid[l] = 0; m_pend[l] = 0;
            end else begin
                m_valid[l] = 0;
                if (m_pend[l] && cyc + 1 == m_due[l]) begin
                    m_valid[l] = 1; m_data[l] = m_pdata[l];
                    m_dest[l]  = m_pdest[l]; m_rw[l] = m_prw[l]; m_pend[l] = 0;
                end
                if (bus_if.InValid[l] && rdy) begin
                    if (op == 4'b1010) begin
                        m_pend[l]  = 1; m_due[l] = cyc + MC;
                        m_pdata[l] = a * b;
                        m_pdest[l] = bus_if.Dest[l*TW +: TW];
                        m_prw[l]   = bus_if.RegWrite[l];
                    end else begin
                        m_valid[l] = 1; m_data[l] = ref_alu(op, a, b);
                        m_dest[l]  = bus_if.Dest[l*TW +: TW];
                        m_rw[l]    = bus_if.RegWrite[l];
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus_if.InValid = '0;
        bus_if.Flush   = 1'b0;
    endtask

    task automatic issue(input int l, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] d, input logic rw);
        bus_if.InValid[l]           = 1'b1;
        bus_if.ALUControl[l*4 +: 4] = op;
        bus_if.SrcA[l*DW +: DW]     = a;
        bus_if.SrcB[l*DW +: DW]     = b;
        bus_if.Dest[l*TW +: TW]     = d;
        bus_if.RegWrite[l]          = rw;
    endtask

    always @(negedge clk) begin : p_compare
        logic          eh;
        logic [DW-1:0] ed;
        logic [TW-1:0] t;
        if (chk_en) begin
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("InReady[%0d]", l), bus_if.InReady[l], exp_ready(l));
                chk($sformatf("ResValid[%0d]", l), bus_if.ResValid[l], m_valid[l]);
                chk($sformatf("ResData[%0d]", l), bus_if.ResData[l*DW +: DW], m_data[l]);
                chk($sformatf("ResDest[%0d]", l), bus_if.ResDest[l*TW +: TW], m_dest[l]);
                chk($sformatf("ResRegWrite[%0d]", l), bus_if.ResRegWrite[l], m_rw[l]);
            end
            for (int j = 0; j < NS; j++) begin
                t  = bus_if.SnoopTag[j*TW +: TW];
                eh = 0;
                ed = '0;
                for (int l = 0; l < NL; l++) begin
                    if (!eh && m_valid[l] && m_rw[l] && m_dest[l] == t) begin
                        eh = 1; ed = m_data[l];
                    end
                end
                chk($sformatf("SnoopHit[%0d]", j), bus_if.SnoopHit[j], eh);
                chk($sformatf("SnoopData[%0d]", j), bus_if.SnoopData[j*DW +: DW], ed);
            end
        end
    end

    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hA, 4'hA, 4'hF};

    initial begin
        bus_if.Flush = 0; bus_if.InValid = '0; bus_if.ALUControl = '0;
        bus_if.SrcA = '0; bus_if.SrcB = '0; bus_if.Dest = '0;
        bus_if.RegWrite = '0; bus_if.SnoopTag = '0;

        // Reset held for two edges
        rst = 1'b1;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_inready", bus_if.InReady, 2'b00);
        chk("rst_resvalid", bus_if.ResValid, 2'b00);
        chk("rst_resdata", bus_if.ResData, 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_inready", bus_if.InReady, 2'b11);

        // ADD 7+5 and snoop hit/miss
        issue(0, 4'b0010, 7, 5, 3, 1);
        tick(); idle();
        bus_if.SnoopTag[0*TW +: TW] = 3;
        bus_if.SnoopTag[1*TW +: TW] = 4;
        @(negedge clk);
        chk("add_valid", bus_if.ResValid, 2'b01);
        chk("add_data", bus_if.ResData[31:0], 12);
        chk("add_dest", bus_if.ResDest[31:0], 3);
        chk("snoop3_hit", bus_if.SnoopHit[0], 1);
        chk("snoop3_data", bus_if.SnoopData[31:0], 12);
        chk("snoop4_hit", bus_if.SnoopHit[1], 0);
        chk("snoop4_data", bus_if.SnoopData[63:32], 0);

        issue(1, 4'b0110, 0, 1, 4, 1);
        tick(); idle();
        @(negedge clk);
        chk("sub_wrap", bus_if.ResData[63:32], 32'hFFFF_FFFF);
        issue(1, 4'b0111, 32'hFFFF_FFFF, 1, 4, 1);
        tick(); idle();
        @(negedge clk);
        chk("slt_signed", bus_if.ResData[63:32], 1);
        issue(1, 4'b1111, 5, 6, 4, 1);
        tick(); idle();
        @(negedge clk);
        chk("bad_opcode", bus_if.ResData[63:32], 0);
        chk("bad_opcode_valid", bus_if.ResValid[1], 1);

        // MUL 6*7 on lane 0 alongside an ADD on lane 1
        issue(0, 4'b1010, 6, 7, 5, 1);
        issue(1, 4'b0010, 1, 2, 6, 1);
        tick(); idle();
        @(negedge clk);
        chk("mul_side_add_valid", bus_if.ResValid[1], 1);
        chk("mul_side_add_data", bus_if.ResData[63:32], 3);
        for (int i = 0; i < MC - 1; i++) begin
            if (i > 0) begin
                tick();
                @(negedge clk);
            end
            chk("mul_busy_ready", bus_if.InReady[0], 0);
            chk("mul_busy_valid", bus_if.ResValid[0], 0);
        end
        tick();
        issue(0, 4'b0010, 1, 1, 7, 1);
        @(negedge clk);
        chk("mul_done_valid", bus_if.ResValid[0], 1);
        chk("mul_done_data", bus_if.ResData[31:0], 42);
        chk("mul_done_ready", bus_if.InReady[0], 1);
        tick(); idle();
        @(negedge clk);
        chk("b2b_after_mul_data", bus_if.ResData[31:0], 2);

        // Duplicate destination: lowest lane wins the snoop
        issue(0, 4'b0010, 0, 1, 9, 1);
        issue(1, 4'b0010, 0, 2, 9, 1);
        tick(); idle();
        bus_if.SnoopTag[0*TW +: TW] = 9;
        @(negedge clk);
        chk("dup_hit", bus_if.SnoopHit[0], 1);
        chk("dup_data", bus_if.SnoopData[31:0], 1);

        // Flush two cycles into a MUL, with an ADD offered during flush
        issue(0, 4'b1010, 3, 3, 2, 1);
        tick(); idle();
        tick();
        bus_if.Flush = 1'b1;
        issue(1, 4'b0010, 4, 4, 2, 1);
        tick(); idle();
        @(negedge clk);
        chk("flush_ready", bus_if.InReady[0], 1);
        chk("flush_no_result", bus_if.ResValid, 2'b00);
        for (int i = 0; i < MC; i++) begin
            tick();
            @(negedge clk);
            chk("flush_never_valid", bus_if.ResValid, 2'b00);
        end

        // Randomized traffic with occasional reset and flush
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 149) == 0);
            bus_if.Flush = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < NL; l++) begin
                logic [3:0]    op;
                logic [DW-1:0] a, b;
                op = ops[$urandom_range(0, 11)];
                if ($urandom_range(0, 15) == 0) op = 4'($urandom);
                a = $urandom;
                b = $urandom;
                if ($urandom_range(0, 1) == 0) a = DW'($urandom_range(0, 31));
                if ($urandom_range(0, 1) == 0) b = DW'($urandom_range(0, 31));
                issue(l, op, a, b, TW'($urandom_range(0, 7)), 1'($urandom));
                bus_if.InValid[l] = ($urandom_range(0, 9) < 7);
            end
            for (int j = 0; j < NS; j++)
                bus_if.SnoopTag[j*TW +: TW] = TW'($urandom_range(0, 7));
            tick();
        end

        rst = 1'b0;
        idle();
        for (int i = 0; i < MC + 2; i++) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
